lfsr_burst_ctrl: RTL and testbench

- Sequencer for an internal 8-bit Fibonacci PRBS register.
- Accepts a seed load and a burst-length command, then streams that many pseudo-random bytes over a valid/ready interface.
- Reports completion and seed errors.
- Sits between a test/host controller and any consumer of PRBS data (stimulus generation, scrambling). The PRBS state persists across bursts.

---
 rtl/lfsr_burst_ctrl.sv | 127 ++++++++++++
 tb/tb_lfsr_burst_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: burst sequencer around an 8-bit Fibonacci PRBS register.
// A host loads a seed and a burst length. The block then streams that many
// PRBS bytes over a valid/ready interface and pulses done once at the end.
// The PRBS state persists across bursts, so each new burst continues the
// sequence where the previous one stopped.
module lfsr_burst_ctrl #(
    parameter logic [7:0]  RESET_SEED = 8'h01,
    parameter int unsigned LEN_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [7:0]       seed,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             abort,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             err_seed
);

    // The count is one bit wider than len, so that a len of 0 can encode
    // a full burst of 2**LEN_W words.
    localparam int unsigned CNT_W = LEN_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       s_q, s_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Fibonacci taps 8,6,5,4 (x^8+x^6+x^5+x^4+1). This polynomial is maximal
    // length, so the register never leaves the set of nonzero states.
    function automatic logic [7:0] prbs_step(input logic [7:0] v);
        return {v[4] ^ v[3] ^ v[2] ^ v[0], v[7:1]};
    endfunction

    // State register: asynchronous reset back to the idle/reset-seed state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            s_q     <= RESET_SEED;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here, so every register samples
            // the values from before the edge, whatever the statement order.
            state_q <= state_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. abort takes priority over seed writes, start and the handshake.
    always_comb begin
        // NOTE: every variable gets its hold value first. Any path that does
        // not assign it again then keeps the value, and no latch is inferred.
        state_d = state_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        err_d   = err_q;

        if (abort) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // The seed is applied before start, so a burst started
                    // in the same cycle begins with the new seed.
                    if (seed_we) begin
                        if (seed != 8'h00) begin
                            s_d   = seed;
                            err_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                    if (start) begin
                        cnt_d   = (len == '0) ? {1'b1, {LEN_W{1'b0}}}
                                              : {1'b0, len};
                        state_d = RUN;
                        // A rejected zero seed in the same cycle keeps err_seed set.
                        if (!seed_we) begin
                            err_d = 1'b0;
                        end
                    end
                end
                RUN: begin
                    // out_valid is 1 throughout RUN, so the handshake
                    // reduces to out_ready.
                    if (out_ready) begin
                        s_d   = prbs_step(s_q);
                        cnt_d = cnt_q - CNT_W'(1);
                        if (cnt_q == CNT_W'(1)) begin
                            state_d = FIN;
                        end
                    end
                end
                FIN: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from registers only, so none depend on the inputs.
    always_comb begin
        out_data  = s_q;
        out_valid = (state_q == RUN);
        busy      = (state_q == RUN);
        done      = (state_q == FIN);
        err_seed  = err_q;
    end

endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// tb_lfsr_burst_ctrl: directed bench with a reference PRBS model and a scoreboard.
module tb_lfsr_burst_ctrl;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             seed_we = 1'b0;
    logic [7:0]       seed = 8'h00;
    logic             start = 1'b0;
    logic [LEN_W-1:0] len = '0;
    logic             abort = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic             busy;
    logic             done;
    logic             err_seed;

    int         total = 0;
    int         bad = 0;
    int         acc = 0;
    int         done_cnt = 0;
    logic [7:0] m_s = 8'h01;
    logic [7:0] sb[$];
    logic [7:0] first_w = 8'h00;
    logic [7:0] last_w = 8'h00;

    lfsr_burst_ctrl #(.RESET_SEED(8'h01), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .seed_we   (seed_we),
        .seed      (seed),
        .start     (start),
        .len       (len),
        .abort     (abort),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .err_seed  (err_seed)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] prbs(input logic [7:0] v);
        logic fb;
        fb = v[4] ^ v[3] ^ v[2] ^ v[0];
        return {fb, v[7:1]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_burst(input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(m_s);
            m_s = prbs(m_s);
        end
    endtask

    // Score any handshake due at the coming edge, then advance one cycle and
    // sample the outputs 1 time unit after the edge.
    task automatic tick();
        logic       hold;
        logic [7:0] exp;
        hold = out_valid && !out_ready && !abort;
        if (out_valid && out_ready && !abort) begin
            check("sb_has_word", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check("word", 32'(out_data), 32'(exp));
            end
            if (acc == 0) first_w = out_data;
            last_w = out_data;
            acc++;
        end
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        if (hold && sb.size() > 0) check("hold", 32'(out_data), 32'(sb[0]));
    endtask

    task automatic start_burst(input int l);
        start = 1'b1;
        len   = LEN_W'(l);
        push_burst((l == 0) ? 256 : l);
        acc      = 0;
        done_cnt = 0;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        check("valid_after_start", 32'(out_valid), 32'd1);
    endtask

    task automatic wait_done(input logic [31:0] pat, input int plen, input int budget);
        for (int i = 0; i < budget && done_cnt == 0; i++) begin
            out_ready = pat[i % plen];
            tick();
        end
        check("done_seen", 32'(done_cnt), 32'd1);
        check("valid_in_fin", 32'(out_valid), 32'd0);
        check("busy_in_fin", 32'(busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
    endtask

    task automatic fin_exit(input logic start_val);
        start = start_val;
        tick();
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_fin", 32'(busy), 32'd0);
        check("single_done", 32'(done_cnt), 32'd1);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err_seed), 32'd0);
        check("rst_data", 32'(out_data), 32'h01);

        // len=4, ready held high: 01 80 40 20
        start_burst(4);
        wait_done(32'h1, 1, 20);
        check("t1_count", 32'(acc), 32'd4);
        fin_exit(1'b0);

        // seed 10, len=3, ready pattern 1,0,0,1,1: 10 88 C4
        seed_we = 1'b1;
        seed    = 8'h10;
        m_s     = 8'h10;
        tick();
        seed_we = 1'b0;
        check("t2_seed_data", 32'(out_data), 32'h10);
        start_burst(3);
        wait_done(32'h19, 5, 20);
        check("t2_count", 32'(acc), 32'd3);
        fin_exit(1'b0);

        // zero seed rejected, sequence unaffected
        seed_we = 1'b1;
        seed    = 8'h00;
        tick();
        seed_we = 1'b0;
        check("t3_err_set", 32'(err_seed), 32'd1);
        check("t3_s_kept", 32'(out_data), 32'(m_s));
        start_burst(2);
        check("t3_err_clr", 32'(err_seed), 32'd0);
        wait_done(32'h1, 1, 20);
        fin_exit(1'b0);

        // len=0 -> 256 words, word 256 equals word 1
        start_burst(0);
        wait_done(32'h1, 1, 300);
        check("t4_count", 32'(acc), 32'd256);
        check("t4_wrap", 32'(last_w), 32'(first_w));
        fin_exit(1'b0);

        // abort after 3 words, then len=1 yields the 4th value
        start_burst(10);
        out_ready = 1'b1;
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort     = 1'b0;
        out_ready = 1'b0;
        check("t5_valid", 32'(out_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        m_s = sb[0];
        sb.delete();
        repeat (3) tick();
        check("t5_no_done", 32'(done_cnt), 32'd0);
        check("t5_s_kept", 32'(out_data), 32'(m_s));
        start_burst(1);
        wait_done(32'h1, 1, 10);
        fin_exit(1'b0);

        // start/seed_we ignored in RUN; start ignored in FIN
        start_burst(3);
        out_ready = 1'b0;
        start     = 1'b1;
        len       = LEN_W'(5);
        seed_we   = 1'b1;
        seed      = 8'h00;
        tick();
        start   = 1'b0;
        seed_we = 1'b0;
        check("t6_err_run", 32'(err_seed), 32'd0);
        check("t6_busy_run", 32'(busy), 32'd1);
        wait_done(32'h1, 1, 20);
        check("t6_count", 32'(acc), 32'd3);
        fin_exit(1'b1);

        // simultaneous seed 55 and start len=1
        seed_we = 1'b1;
        seed    = 8'h55;
        m_s     = 8'h55;
        start_burst(1);
        seed_we = 1'b0;
        check("t7_first", 32'(out_data), 32'h55);
        wait_done(32'h1, 1, 10);
        fin_exit(1'b0);

        // reset mid-burst
        start_burst(5);
        out_ready = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("t8_valid", 32'(out_valid), 32'd0);
        check("t8_busy", 32'(busy), 32'd0);
        #1 rst = 1'b0;
        out_ready = 1'b0;
        m_s = 8'h01;
        sb.delete();
        check("t8_data", 32'(out_data), 32'h01);
        tick();
        check("t8_no_done", 32'(done_cnt), 32'd0);
        start_burst(2);
        wait_done(32'h1, 1, 10);
        fin_exit(1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
